// File: rtl/ram_bist_ctrl.sv
// March-test BIST initiator for a 16x8 single-port-pair RAM: W_A/R_A (0x55 up), W_B/R_B (0xAA down).
// Define RAM_BIST_ADDR_PATTERN_EN to append W_C/R_C (data = address, ascending) for decoder-aliasing faults.
module ram_bist_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] wr_data,
    output logic              wen,
    output logic [ADDR_W-1:0] w_addr,
    output logic              ren,
    output logic [ADDR_W-1:0] r_addr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [7:0]        fail_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_A,
        S_R_A,
        S_W_B,
        S_R_B,
`ifdef RAM_BIST_ADDR_PATTERN_EN
        S_W_C,
        S_R_C,
`endif
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [DATA_W-1:0] PAT_A    = {(DATA_W/2){2'b01}};
    localparam logic [DATA_W-1:0] PAT_B    = {(DATA_W/2){2'b10}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                wen_q, wen_d;
    logic                ren_q, ren_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                cmp_vld_q, cmp_vld_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
    logic [7:0]          fail_cnt_q, fail_cnt_d;
    logic [ADDR_W-1:0]   ffa_q, ffa_d;
    logic                start_acc;
    logic                last_asc;
    logic                last_desc;

    assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_asc  = (cnt_q == ADDR_MAX);
    assign last_desc = (cnt_q == '0);

    // Compare stage: expected data is latched while ren is out, checked one cycle later.
    always_comb begin
        cmp_vld_d  = ren_q;
        cmp_addr_d = r_addr_q;
        exp_d      = '0;
        case (state_q)
            S_R_A:   exp_d = PAT_A;
            S_R_B:   exp_d = PAT_B;
`ifdef RAM_BIST_ADDR_PATTERN_EN
            S_R_C:   exp_d = DATA_W'(r_addr_q);
`endif
            default: exp_d = '0;
        endcase
        fail_cnt_d = fail_cnt_q;
        ffa_d      = ffa_q;
        if (cmp_vld_q && (ram_dout != exp_q)) begin
            if (fail_cnt_q != 8'hFF) begin
                fail_cnt_d = fail_cnt_q + 8'd1;
            end
            if (fail_cnt_q == '0) begin
                ffa_d = cmp_addr_q;
            end
        end
        if (start_acc) begin
            fail_cnt_d = '0;
            ffa_d      = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_W_A;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_W_A: begin
                if (last_asc) begin
                    state_d = S_R_A;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_R_A: begin
                if (last_asc) begin
                    state_d = S_W_B;
                    cnt_d   = ADDR_MAX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_W_B: begin
                if (last_desc) begin
                    state_d = S_R_B;
                    cnt_d   = ADDR_MAX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_R_B: begin
                if (last_desc) begin
`ifdef RAM_BIST_ADDR_PATTERN_EN
                    state_d = S_W_C;
`else
                    state_d = S_FLUSH;
`endif
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef RAM_BIST_ADDR_PATTERN_EN
            S_W_C: begin
                if (last_asc) begin
                    state_d = S_R_C;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_R_C: begin
                if (last_asc) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_FLUSH: begin
                // The final read is compared on this edge, so the verdict uses the updated count.
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (fail_cnt_d == '0);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wen_d     = 1'b0;
        ren_d     = 1'b0;
        w_addr_d  = '0;
        r_addr_d  = '0;
        wr_data_d = '0;
        case (state_d)
            S_W_A: begin
                wen_d     = 1'b1;
                w_addr_d  = cnt_d;
                wr_data_d = PAT_A;
            end
            S_W_B: begin
                wen_d     = 1'b1;
                w_addr_d  = cnt_d;
                wr_data_d = PAT_B;
            end
            S_R_A, S_R_B: begin
                ren_d    = 1'b1;
                r_addr_d = cnt_d;
            end
`ifdef RAM_BIST_ADDR_PATTERN_EN
            S_W_C: begin
                wen_d     = 1'b1;
                w_addr_d  = cnt_d;
                wr_data_d = DATA_W'(cnt_d);
            end
            S_R_C: begin
                ren_d    = 1'b1;
                r_addr_d = cnt_d;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            w_addr_q   <= '0;
            r_addr_q   <= '0;
            wr_data_q  <= '0;
            cmp_vld_q  <= 1'b0;
            exp_q      <= '0;
            cmp_addr_q <= '0;
            fail_cnt_q <= '0;
            ffa_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
            w_addr_q   <= w_addr_d;
            r_addr_q   <= r_addr_d;
            wr_data_q  <= wr_data_d;
            cmp_vld_q  <= cmp_vld_d;
            exp_q      <= exp_d;
            cmp_addr_q <= cmp_addr_d;
            fail_cnt_q <= fail_cnt_d;
            ffa_q      <= ffa_d;
        end
    end

    assign wr_data         = wr_data_q;
    assign wen             = wen_q;
    assign w_addr          = w_addr_q;
    assign ren             = ren_q;
    assign r_addr          = r_addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign first_fail_addr = ffa_q;
    assign fail_count      = fail_cnt_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: a fault-injecting RAM model plus a march-level reference
// that predicts every RAM access (with cycle) and the final verdict.
module tb_ram_bist_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
`ifdef RAM_BIST_ADDR_PATTERN_EN
    localparam int NPH = 6;
`else
    localparam int NPH = 4;
`endif

    logic          clock = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] ram_dout = '0;
    logic [DW-1:0] wr_data;
    logic          wen;
    logic [AW-1:0] w_addr;
    logic          ren;
    logic [AW-1:0] r_addr;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] first_fail_addr;
    logic [7:0]    fail_count;

    ram_bist_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .rst(rst), .start(start), .ram_dout(ram_dout),
        .wr_data(wr_data), .wen(wen), .w_addr(w_addr), .ren(ren), .r_addr(r_addr),
        .busy(busy), .done(done), .pass(pass),
        .first_fail_addr(first_fail_addr), .fail_count(fail_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Fault configuration shared by the RAM model and the reference
    bit f_alias = 0;
    bit f_zero  = 0;
    bit f_stuck = 0;
    int f_saddr = 0;
    int f_sbit  = 0;
    bit f_sval  = 0;

    function automatic int phys(input int a);
        return f_alias ? (a & 7) : a;
    endfunction

    function automatic logic [7:0] stick(input int pa, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (f_stuck && pa == f_saddr) r[f_sbit] = f_sval;
        return r;
    endfunction

    logic [7:0] mem [16];
    always @(posedge clock) begin
        if (ren) ram_dout <= f_zero ? 8'h00 : mem[4'(phys(int'(r_addr)))];
        if (wen) mem[4'(phys(int'(w_addr)))] = stick(phys(int'(w_addr)), wr_data);
    end

    typedef struct packed { int cyc; logic wr; int addr; int data; } acc_t;
    typedef struct packed { int cyc; logic ok; int fc; int ffa; } res_t;
    acc_t acc_q[$];
    res_t res_q[$];

    // March reference: phases alternate write/read; phases 2,3 run descending.
    task automatic predict(input int e0, input int limit, input bit with_res);
        logic [7:0] m [16];
        int fc, ffa, n, a, d;
        bit wr, desc;
        logic [7:0] got;
        acc_t e;
        res_t r;
        fc = 0; ffa = 0; n = 0;
        for (int p = 0; p < NPH; p++) begin
            wr   = (p % 2 == 0);
            desc = (p == 2 || p == 3);
            for (int i = 0; i < 16; i++) begin
                a = desc ? 15 - i : i;
                d = (p < 2) ? 32'h55 : (p < 4) ? 32'hAA : a;
                if (n < limit) begin
                    e.cyc = e0 + n; e.wr = wr; e.addr = a; e.data = wr ? d : 0;
                    acc_q.push_back(e);
                end
                n++;
                if (wr) m[4'(phys(a))] = stick(phys(a), 8'(d));
                else begin
                    got = f_zero ? 8'h00 : m[4'(phys(a))];
                    if (got != 8'(d)) begin
                        if (fc == 0) ffa = a;
                        if (fc < 255) fc++;
                    end
                end
            end
        end
        if (with_res) begin
            r.cyc = e0 + NPH * 16 + 1; r.ok = (fc == 0); r.fc = fc; r.ffa = ffa;
            res_q.push_back(r);
        end
    endtask

    // Monitor: consumes scoreboard entries whenever the DUT drives the RAM or finishes
    bit prev_done = 0;
    always @(negedge clock) begin
        acc_t e;
        res_t r;
        chk("wen_ren_exclusive", 64'(wen && ren), 64'd0);
        chk("idle_ports_zero", 64'({(wen ? 4'd0 : w_addr), (wen ? 8'd0 : wr_data), (ren ? 4'd0 : r_addr)}), 64'd0);
        if (wen || ren) begin
            if (acc_q.size() == 0) chk("access_expected", 64'(acc_q.size()), 64'd1);
            else begin
                e = acc_q.pop_front();
                chk("access", 64'({32'(cyc), 8'(wen ? w_addr : r_addr), 8'(wen ? wr_data : 8'd0), wen}),
                              64'({32'(e.cyc), 8'(e.addr), 8'(e.data), e.wr}));
                chk("busy_during_access", 64'(busy), 64'd1);
            end
        end
        if (done && !prev_done) begin
            if (res_q.size() == 0) chk("result_expected", 64'(res_q.size()), 64'd1);
            else begin
                r = res_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(r.cyc));
                chk("pass", 64'(pass), 64'(r.ok));
                chk("fail_count", 64'(fail_count), 64'(r.fc));
                chk("first_fail_addr", 64'(first_fail_addr), 64'(r.ffa));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
        prev_done = done;
    end

    function automatic logic [63:0] outs();
        return 64'({wr_data, wen, w_addr, ren, r_addr, busy, done, pass, first_fail_addr, fail_count});
    endfunction

    task automatic set_fault(input int mode);
        f_alias = (mode == 2);
        f_zero  = (mode == 3);
        f_stuck = (mode == 1 || mode == 4);
        if (mode == 4) begin
            f_saddr = 5; f_sbit = 0; f_sval = 1;
        end else begin
            f_saddr = $urandom_range(0, 15); f_sbit = $urandom_range(0, 7); f_sval = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 300) begin
            @(negedge clock);
            k++;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    task automatic run_pulse(input int mode);
        set_fault(mode);
        repeat ($urandom_range(1, 5)) @(negedge clock);
        predict(cyc + 1, 1 << 30, 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("done_reached");
        @(negedge clock);
    endtask

    initial begin
        int e0, k;
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_outputs", outs(), 64'd0);
        rst = 1'b0;

        run_pulse(0);
        run_pulse(4);
        run_pulse(2);
        run_pulse(3);

        // Reset in the middle of R_A
        set_fault(0);
        @(negedge clock);
        e0 = cyc + 1;
        predict(e0, 20, 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait (cyc == e0 + 20);
        #1 rst = 1'b1;
        #1 chk("midtest_reset_outputs", outs(), 64'd0);
        @(negedge clock);
        rst = 1'b0;
        run_pulse(0);

        // start held high: ignored while busy, re-accepted the cycle after done
        set_fault(4);
        @(negedge clock);
        e0 = cyc + 1;
        predict(e0, 1 << 30, 1);
        predict(e0 + NPH * 16 + 2, 1 << 30, 1);
        start = 1'b1;
        @(negedge clock);
        wait_done("held_first_done");
        k = 0;
        while (done && k < 10) begin
            @(negedge clock);
            k++;
        end
        chk("held_done_cleared", 64'(done), 64'd0);
        start = 1'b0;
        wait_done("held_second_done");
        @(negedge clock);

        for (int i = 0; i < 6; i++) run_pulse($urandom_range(0, 3));

        repeat (3) @(negedge clock);
        chk("access_queue_drained", 64'(acc_q.size()), 64'd0);
        chk("result_queue_drained", 64'(res_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
